sc_trace_capture: RTL and testbench
===================================

Name: sc_trace_capture

Overview:
- Execution-trace capture stage directly downstream of sc_computer.
- Every clock it consumes the CPU's committed pc/inst/aluout outputs into a circular buffer.
- Stops a programmable number of cycles after a PC-match trigger.
- Replays the captured window oldest-first over a simple request/valid readout port for bench or debug-host inspection.

Parameters:
DEPTH_LOG2, 4, log2 of buffer depth (DEPTH = 16 entries of pc/inst/aluout).
POST_TRIG, 8, entries written after the trigger entry; legal range 0..DEPTH-1.

Ports:
clock  input  1  system clock, same clock as sc_computer's clock.
resetn  input  1  asynchronous active-low reset.
pc  input  32  CPU program counter of current instruction.
inst  input  32  CPU instruction word.
aluout  input  32  CPU ALU result.
arm  input  1  single-cycle pulse: clear buffer and start capture.
trig_pc  input  32  trigger address; compared against pc.
rd_req  input  1  readout request, one entry per asserted cycle.
state  output  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
triggered  output  1  sticky: trigger seen since last arm.
count  output  DEPTH_LOG2+1  valid entries held, saturates at DEPTH.
rd_valid  output  1  rd_pc/rd_inst/rd_alu valid this cycle.
rd_last  output  1  qualifies rd_valid: final entry of window.
rd_pc  output  32  replayed pc.
rd_inst  output  32  replayed inst.
rd_alu  output  32  replayed aluout.

Behaviour:
- Reset (async, resetn=0), regardless of state:
  - state=IDLE; triggered=0, count=0, rd_valid=0, rd_last=0.
  - rd_pc/rd_inst/rd_alu=0; wr_ptr, rd_cnt and post counter cleared.
  - Buffer contents undefined.
  - Reset mid-capture or mid-readout discards everything.
- All sequential updates on rising clock edge; inputs sampled at that edge.
- IDLE: no writes. arm=1 -> ARMED with wr_ptr=0, count=0, triggered=0, rd_cnt=0.
- ARMED:
  - Each edge writes {pc,inst,aluout} at wr_ptr.
  - wr_ptr increments modulo DEPTH (wraps 15->0, overwriting oldest); count increments, saturating at DEPTH.
  - If pc==trig_pc on the same edge: that entry is written, triggered=1, post counter loaded with POST_TRIG.
  - Next state is POST, or DONE directly if POST_TRIG=0.
- POST:
  - Each edge writes one entry and decrements the post counter.
  - The edge writing the POST_TRIG-th post-trigger entry moves to DONE.
  - Further pc==trig_pc matches are ignored.
- DONE: no writes. Oldest index = 0 if count<DEPTH, else wr_ptr.
- Readout handshake:
  - rd_req=1 in DONE with rd_cnt<count: next cycle rd_valid=1 with entry (oldest+rd_cnt) mod DEPTH; rd_cnt increments.
  - rd_last=1 on the entry where rd_cnt==count-1.
  - Latency is exactly 1 cycle; back-to-back rd_req streams one entry per cycle.
  - rd_req when rd_cnt==count, or in any state other than DONE: ignored, rd_valid=0 next cycle.
  - rd_valid is a 1-cycle pulse per request.
  - rd_pc/rd_inst/rd_alu hold their last value when rd_valid=0.
- arm=1 in ARMED, POST or DONE: aborts and restarts as from IDLE in the same edge (buffer cleared logically via count=0). arm has priority over trigger and rd_req on the same edge.
- No trigger ever: stays ARMED indefinitely, buffer wrapping.
- Comparison is full 32-bit equality; aluout/inst are not compared.

Test Plan:
- Reset then pulse arm; drive pc=0,4,8,...; trig_pc=0x20 -> triggered=1 at pc=0x20. DONE after pc=0x40 (8 post entries). count=17 saturates to 16. Readout yields pc 0x04..0x40 oldest-first, rd_last on pc=0x40.
- Trigger before wrap: trig_pc=0x8 -> count=11 at DONE. Readout pc 0x00..0x28, 11 rd_valid pulses, 12th rd_req gives rd_valid=0.
- POST_TRIG=0 instance, trig_pc=0xC -> DONE same edge. count=4, last replayed pc=0xC with rd_last=1.
- Long run with no trigger (100 cycles) -> state stays 1. count=16. rd_req ignored (rd_valid=0).
- arm pulse during POST -> state=ARMED, count=0, triggered=0 next cycle; subsequent trigger behaves as first scenario.
- Assert resetn=0 mid-readout after 5 entries -> all outputs 0, state=0 immediately (asynchronous, no clock edge needed).

Source files
------------

// File: rtl/sc_trace_capture.sv
// Execution-trace capture stage for sc_computer: circular buffer of pc/inst/aluout
// that stops POST_TRIG entries after a PC-match trigger and replays oldest-first.
module sc_trace_capture #(
    parameter int DEPTH_LOG2 = 4,
    parameter int POST_TRIG  = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [31:0]           pc,
    input  logic [31:0]           inst,
    input  logic [31:0]           aluout,
    input  logic                  arm,
    input  logic [31:0]           trig_pc,
    input  logic                  rd_req,
    output logic [1:0]            state,
    output logic                  triggered,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic [31:0]           rd_pc,
    output logic [31:0]           rd_inst,
    output logic [31:0]           rd_alu
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] POST_LD = DEPTH_LOG2'(POST_TRIG);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
    } entry_t;

    state_e                state_q;
    logic                  triggered_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] post_q;
    logic [DEPTH_LOG2:0]   rd_cnt_q;
    logic                  rd_valid_q;
    logic                  rd_last_q;
    entry_t                rd_q;
    entry_t                mem_q [DEPTH];

    logic                  capture_en;
    logic                  rd_ok;
    logic [DEPTH_LOG2:0]   count_d;
    logic [DEPTH_LOG2-1:0] oldest;
    logic [DEPTH_LOG2-1:0] rd_idx_d;

    // arm wins over everything, so the arm edge itself never writes an entry
    assign capture_en = (state_q == S_ARMED || state_q == S_POST) && !arm;
    assign count_d    = (count_q == DEPTH_C) ? count_q : count_q + CNT_ONE;
    // count saturates at DEPTH, so its MSB alone says the buffer has wrapped
    assign oldest     = count_q[DEPTH_LOG2] ? wr_ptr_q : '0;
    assign rd_idx_d   = oldest + rd_cnt_q[DEPTH_LOG2-1:0];
    assign rd_ok      = (state_q == S_DONE) && rd_req && (rd_cnt_q < count_q);

    // NOTE: the trace RAM has no reset; count=0 is what marks it empty, and
    // leaving it unreset lets it map onto plain memory.
    always_ff @(posedge clock) begin
        if (capture_en) begin
            mem_q[wr_ptr_q] <= '{pc: pc, inst: inst, alu: aluout};
        end
    end

    // NOTE: every sequential assignment is non-blocking so all state updates
    // see the values from before the edge, regardless of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            triggered_q <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            post_q      <= '0;
            rd_cnt_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_q        <= '0;
        end else if (arm) begin
            state_q     <= S_ARMED;
            triggered_q <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            post_q      <= '0;
            rd_cnt_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            rd_last_q  <= rd_ok && (rd_cnt_q == count_q - CNT_ONE);
            if (rd_ok) begin
                rd_q     <= mem_q[rd_idx_d];
                rd_cnt_q <= rd_cnt_q + CNT_ONE;
            end
            case (state_q)
                S_ARMED: begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                    count_q  <= count_d;
                    if (pc == trig_pc) begin
                        triggered_q <= 1'b1;
                        post_q      <= POST_LD;
                        state_q     <= (POST_TRIG == 0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                    count_q  <= count_d;
                    post_q   <= post_q - PTR_ONE;
                    if (post_q == PTR_ONE) begin
                        state_q <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state     = state_q;
    assign triggered = triggered_q;
    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign rd_pc     = rd_q.pc;
    assign rd_inst   = rd_q.inst;
    assign rd_alu    = rd_q.alu;

endmodule

// File: tb/tb_sc_trace_capture.sv
// Bench for sc_trace_capture: a POST_TRIG=8 and a POST_TRIG=0 instance share one pc
// stream; capture scenarios come from a table, readout is checked via a queue.
module tb_sc_trace_capture;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] pc, inst, aluout, trig_pc;
    logic        arm, rd_req, sel;

    logic        arm0, arm1, rd_req0, rd_req1;
    logic [1:0]  state0, state1;
    logic        trig0, trig1, rdv0, rdv1, rdl0, rdl1;
    logic [4:0]  cnt0, cnt1;
    logic [31:0] rpc0, rpc1, rinst0, rinst1, ralu0, ralu1;

    logic [1:0]  st;
    logic        trg, rdv, rdl;
    logic [4:0]  cnt;
    logic [31:0] rpc, rinst, ralu;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] trig;
        bit          sel;
        int          done_k;
        int          count;
    } row_t;

    typedef struct {
        bit          valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
        bit          last;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    row_t    rows[5];

    assign arm0    = arm && !sel;
    assign arm1    = arm && sel;
    assign rd_req0 = rd_req && !sel;
    assign rd_req1 = rd_req && sel;

    always_comb begin
        st    = sel ? state1 : state0;
        trg   = sel ? trig1  : trig0;
        cnt   = sel ? cnt1   : cnt0;
        rdv   = sel ? rdv1   : rdv0;
        rdl   = sel ? rdl1   : rdl0;
        rpc   = sel ? rpc1   : rpc0;
        rinst = sel ? rinst1 : rinst0;
        ralu  = sel ? ralu1  : ralu0;
    end

    sc_trace_capture #(.DEPTH_LOG2(4), .POST_TRIG(8)) dut0 (
        .clock(clock), .resetn(resetn), .pc(pc), .inst(inst), .aluout(aluout),
        .arm(arm0), .trig_pc(trig_pc), .rd_req(rd_req0),
        .state(state0), .triggered(trig0), .count(cnt0), .rd_valid(rdv0),
        .rd_last(rdl0), .rd_pc(rpc0), .rd_inst(rinst0), .rd_alu(ralu0)
    );

    sc_trace_capture #(.DEPTH_LOG2(4), .POST_TRIG(0)) dut1 (
        .clock(clock), .resetn(resetn), .pc(pc), .inst(inst), .aluout(aluout),
        .arm(arm1), .trig_pc(trig_pc), .rd_req(rd_req1),
        .state(state1), .triggered(trig1), .count(cnt1), .rd_valid(rdv1),
        .rd_last(rdl1), .rd_pc(rpc1), .rd_inst(rinst1), .rd_alu(ralu1)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] inst_of(input logic [31:0] p);
        return p ^ 32'hDEAD_0000;
    endfunction

    function automatic logic [31:0] alu_of(input logic [31:0] p);
        return p + 32'h0000_1000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] p);
        pc     = p;
        inst   = inst_of(p);
        aluout = alu_of(p);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_state", 32'(st), 32'd1);
        check("arm_count", 32'(cnt), 32'd0);
        check("arm_triggered", 32'(trg), 32'd0);
    endtask

    // Drive pc=0,4,8,... until DONE; pc stream restarts at 0 after every arm.
    task automatic run_capture(input logic [31:0] t, input bit s, input bit with_arm,
                               input int exp_done_k, input int exp_count);
        bit done = 1'b0;
        sel     = s;
        trig_pc = t;
        if (with_arm) do_arm();
        for (int k = 0; k < 64 && !done; k++) begin
            set_pc(32'(4 * k));
            tick();
            if (32'(4 * k) == t) check("triggered_at_match", 32'(trg), 32'd1);
            if (st == 2'd3) begin
                done = 1'b1;
                check("done_at_k", 32'(k), 32'(exp_done_k));
            end
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
        check("done_count", 32'(cnt), 32'(exp_count));
        check("done_triggered", 32'(trg), 32'd1);
    endtask

    // Issue n_req back-to-back requests; expected replies are queued at drive time.
    task automatic do_read(input int first_k, input int n_cnt, input int n_req);
        rd_exp_t e, got_e;
        for (int i = 0; i < n_req; i++) begin
            e.valid = (i < n_cnt);
            e.pc    = 32'(4 * (first_k + i));
            e.inst  = inst_of(e.pc);
            e.alu   = alu_of(e.pc);
            e.last  = (i == n_cnt - 1);
            sb_q.push_back(e);
            rd_req = 1'b1;
            tick();
            got_e = sb_q.pop_front();
            check("rd_valid", 32'(rdv), 32'(got_e.valid));
            if (got_e.valid) begin
                check("rd_pc", rpc, got_e.pc);
                check("rd_inst", rinst, got_e.inst);
                check("rd_alu", ralu, got_e.alu);
                check("rd_last", 32'(rdl), 32'(got_e.last));
            end
        end
        rd_req = 1'b0;
        if (n_req > n_cnt) begin
            tick();
            check("idle_rd_valid", 32'(rdv), 32'd0);
            check("rd_pc_hold", rpc, 32'(4 * (first_k + n_cnt - 1)));
        end
    endtask

    initial begin
        rows[0] = '{trig: 32'h20, sel: 1'b0, done_k: 16, count: 16};
        rows[1] = '{trig: 32'h08, sel: 1'b0, done_k: 10, count: 11};
        rows[2] = '{trig: 32'h0C, sel: 1'b1, done_k: 3,  count: 4};
        rows[3] = '{trig: 32'h00, sel: 1'b1, done_k: 0,  count: 1};
        rows[4] = '{trig: 32'h3C, sel: 1'b0, done_k: 23, count: 16};

        resetn = 1'b0; arm = 1'b0; rd_req = 1'b0; sel = 1'b0;
        trig_pc = '0; set_pc(32'h0);
        #12;
        check("reset_state", 32'(st), 32'd0);
        check("reset_count", 32'(cnt), 32'd0);
        check("reset_triggered", 32'(trg), 32'd0);
        check("reset_rd_valid", 32'(rdv), 32'd0);
        check("reset_rd_pc", rpc, 32'd0);
        resetn = 1'b1;
        tick();

        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("idle_rd_req_ignored", 32'(rdv), 32'd0);
        check("idle_state", 32'(st), 32'd0);

        for (int r = 0; r < 5; r++) begin
            run_capture(rows[r].trig, rows[r].sel, 1'b1, rows[r].done_k, rows[r].count);
            do_read(rows[r].done_k - rows[r].count + 1, rows[r].count, rows[r].count + 1);
        end

        // No trigger ever: pc values are multiples of 4, so an odd trig_pc never hits.
        sel = 1'b0;
        trig_pc = 32'hFFFF_FFFF;
        do_arm();
        for (int k = 0; k < 100; k++) begin
            set_pc(32'(4 * k));
            tick();
        end
        check("notrig_state", 32'(st), 32'd1);
        check("notrig_count", 32'(cnt), 32'd16);
        check("notrig_triggered", 32'(trg), 32'd0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("notrig_rd_ignored", 32'(rdv), 32'd0);

        // Abort during POST, then a fresh capture without another arm.
        trig_pc = 32'h20;
        do_arm();
        for (int k = 0; k < 12; k++) begin
            set_pc(32'(4 * k));
            tick();
        end
        check("abort_pre_state", 32'(st), 32'd2);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("abort_state", 32'(st), 32'd1);
        check("abort_count", 32'(cnt), 32'd0);
        check("abort_triggered", 32'(trg), 32'd0);
        run_capture(32'h20, 1'b0, 1'b0, 16, 16);
        do_read(1, 16, 17);

        // Asynchronous reset in the middle of a readout.
        run_capture(32'h20, 1'b0, 1'b1, 16, 16);
        do_read(1, 16, 5);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_state", 32'(st), 32'd0);
        check("async_rst_count", 32'(cnt), 32'd0);
        check("async_rst_triggered", 32'(trg), 32'd0);
        check("async_rst_rd_valid", 32'(rdv), 32'd0);
        check("async_rst_rd_last", 32'(rdl), 32'd0);
        check("async_rst_rd_pc", rpc, 32'd0);
        check("async_rst_rd_inst", rinst, 32'd0);
        check("async_rst_rd_alu", ralu, 32'd0);
        #10;
        resetn = 1'b1;
        tick();
        check("post_rst_state", 32'(st), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
